// File: rtl/sha256_msg_scheduler.sv
// SHA-256 message-schedule generator: expands one 512-bit block to W[0..63] and
// hands it to the compression stage as two 32-word halves with matching K constants.
module sha256_msg_scheduler #(
  parameter int EXP_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              blk_valid,
  output logic              blk_ready,
  input  logic [0:511]      blk_data,
  output logic              sch_valid,
  input  logic              sch_ready,
  output logic              sch_half,
  output logic [0:31][0:31] sch_w,
  output logic [0:31][0:31] sch_k,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_OUT0   = 2'd2;
  localparam logic [1:0] ST_OUT1   = 2'd3;

  localparam logic [6:0] EXP_STEP = 7'(EXP_PER_CYCLE);

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  if ((EXP_PER_CYCLE < 1) || (EXP_PER_CYCLE > 8) || ((48 % EXP_PER_CYCLE) != 0)) begin : g_bad_param
    $error("EXP_PER_CYCLE must be one of 1, 2, 3, 4, 6, 8");
  end

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  logic [1:0]  state;
  logic [6:0]  exp_idx;
  logic [31:0] w_store  [64];
  logic [31:0] win      [64];
  logic [31:0] exp_word [EXP_PER_CYCLE];
  logic [5:0]  exp_t;

  // Words produced in one cycle feed later words of the same cycle through win.
  always_comb begin
    win   = w_store;
    exp_t = '0;
    for (int j = 0; j < EXP_PER_CYCLE; j++) begin
      exp_t = 6'(exp_idx + 7'(j));
      win[exp_t] = sigma1(win[6'(exp_t - 6'd2)]) + win[6'(exp_t - 6'd7)]
                 + sigma0(win[6'(exp_t - 6'd15)]) + win[6'(exp_t - 6'd16)];
      exp_word[j] = win[exp_t];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      exp_idx <= 7'd16;
      sch_w   <= '0;
      sch_k   <= '0;
      for (int i = 0; i < 64; i++) begin
        w_store[i] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (blk_valid) begin
            for (int i = 0; i < 16; i++) begin
              w_store[i] <= blk_data[32*i +: 32];
            end
            exp_idx <= 7'd16;
            state   <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          for (int j = 0; j < EXP_PER_CYCLE; j++) begin
            w_store[6'(exp_idx + 7'(j))] <= exp_word[j];
          end
          exp_idx <= exp_idx + EXP_STEP;
          // The final step writes only words >= 56, so W0..W31 are already settled.
          if (exp_idx + EXP_STEP == 7'd64) begin
            state <= ST_OUT0;
            for (int i = 0; i < 32; i++) begin
              sch_w[i] <= w_store[i];
              sch_k[i] <= K_ROM[i];
            end
          end
        end
        ST_OUT0: begin
          if (sch_ready) begin
            state <= ST_OUT1;
            for (int i = 0; i < 32; i++) begin
              sch_w[i] <= w_store[32+i];
              sch_k[i] <= K_ROM[32+i];
            end
          end
        end
        default: begin
          if (sch_ready) begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign blk_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign sch_valid = (state == ST_OUT0) || (state == ST_OUT1);
  assign sch_half  = (state == ST_OUT1);

endmodule
